cmp_arbiter: RTL and testbench



---
 rtl/cmp_arb_pkg.sv | 14 +
 rtl/cmp_core.sv | 16 +
 rtl/cmp_arbiter.sv | 136 +++++++++++++
 tb/tb_cmp_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_arb_pkg.sv
// Shared types and constants for the round-robin comparator arbiter.
package cmp_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_NREQ  = 2;
    localparam int EQ_CNT_W  = 8;

endpackage

// File: rtl/cmp_core.sv
// Purely combinational unsigned magnitude comparator.
module cmp_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_eq,
    output logic             o_gt,
    output logic             o_lt
);

    assign o_eq = (i_a == i_b);
    assign o_gt = (i_a > i_b);
    assign o_lt = (i_a < i_b);

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one comparator between NREQ requesters.
// Optional equal-result counter is built when CMP_ARB_STATS_EN is defined.
module cmp_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  res_eq,
    output logic                  res_gt,
    output logic                  res_lt,
    output logic                  busy,
    output logic [EQ_CNT_W-1:0]   eq_count
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_win;
    logic [IDX_W-1:0] w_win;
    logic             w_any;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  r_done;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_eq;
    logic             r_gt;
    logic             r_lt;
    logic             r_busy;
    logic             w_eq;
    logic             w_gt;
    logic             w_lt;

    // Scan from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        w_any = 1'b0;
        w_win = r_ptr;
        for (int off = NREQ - 1; off >= 0; off--) begin
            if (req[IDX_W'((int'(r_ptr) + off) % NREQ)]) begin
                w_any = 1'b1;
                w_win = IDX_W'((int'(r_ptr) + off) % NREQ);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_state_next = ST_CMP;
            ST_CMP:  w_state_next = ST_RESP;
            ST_RESP: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    cmp_core #(.WIDTH(WIDTH)) u_core (
        .i_a  (r_a),
        .i_b  (r_b),
        .o_eq (w_eq),
        .o_gt (w_gt),
        .o_lt (w_lt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
            r_win   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_win <= w_win;
                        r_gnt <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
                        r_a   <= a_in[int'(w_win)*WIDTH +: WIDTH];
                        r_b   <= b_in[int'(w_win)*WIDTH +: WIDTH];
                    end
                end
                ST_CMP: begin
                    r_eq   <= w_eq;
                    r_gt   <= w_gt;
                    r_lt   <= w_lt;
                    r_done <= r_gnt;
                    r_gnt  <= '0;
                    r_ptr  <= (int'(r_win) == NREQ - 1) ? '0 : r_win + 1'b1;
                end
                ST_RESP: r_done <= '0;
                default: r_done <= '0;
            endcase
        end
    end

`ifdef CMP_ARB_STATS_EN
    logic [EQ_CNT_W-1:0] r_eq_cnt;

    // Saturating: stays at all-ones once reached.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_eq_cnt <= '0;
        end else if (r_state == ST_CMP && w_eq && r_eq_cnt != '1) begin
            r_eq_cnt <= r_eq_cnt + 1'b1;
        end
    end

    assign eq_count = r_eq_cnt;
`else
    assign eq_count = '0;
`endif

    assign gnt    = r_gnt;
    assign done   = r_done;
    assign res_eq = r_eq;
    assign res_gt = r_gt;
    assign res_lt = r_lt;
    assign busy   = r_busy;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter: stimulus pushes expected results, a monitor pops on done.
module tb_cmp_arbiter;

    localparam int W = 4;
    localparam int N = 2;
    localparam logic [2:0] F_EQ = 3'b100;
    localparam logic [2:0] F_GT = 3'b010;
    localparam logic [2:0] F_LT = 3'b001;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic         res_eq;
    logic         res_gt;
    logic         res_lt;
    logic         busy;
    logic [7:0]   eq_count;

    typedef struct packed {
        logic [1:0] done;
        logic [2:0] flags;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_txn = 0;
    int   exp_cnt = 0;

    cmp_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .a_in     (a_in),
        .b_in     (b_in),
        .gnt      (gnt),
        .done     (done),
        .res_eq   (res_eq),
        .res_gt   (res_gt),
        .res_lt   (res_lt),
        .busy     (busy),
        .eq_count (eq_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    function automatic logic [7:0] cnt_exp();
`ifdef CMP_ARB_STATS_EN
        return 8'(exp_cnt);
`else
        return 8'd0;
`endif
    endfunction

    task automatic push(input logic [1:0] d, input logic [2:0] f);
        exp_t e;
        if (f == F_EQ && exp_cnt < 255) exp_cnt++;
        e.done  = d;
        e.flags = f;
        e.cnt   = cnt_exp();
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int r);
        for (int i = 0; i < 20; i++) begin
            step();
            if (gnt[r]) return;
        end
        check("gnt_timeout", 32'(gnt), 32'(1 << r));
    endtask

    task automatic wait_done(input int r);
        for (int i = 0; i < 20; i++) begin
            step();
            if (done[r]) return;
        end
        check("done_timeout", 32'(done), 32'(1 << r));
    endtask

    task automatic run_one(input int r, input int a, input int b, input logic [2:0] f,
                           input int a_late = -1);
        push(2'(1 << r), f);
        a_in[r*W +: W] = 4'(a);
        b_in[r*W +: W] = 4'(b);
        req[r] = 1'b1;
        wait_gnt(r);
        if (a_late >= 0) a_in[r*W +: W] = 4'(a_late);
        wait_done(r);
        req[r] = 1'b0;
        step();
    endtask

    // Monitor: every done strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (done != '0) begin
            n_txn++;
            $display("txn %0d: done=%b eq/gt/lt=%b%b%b eq_count=%0d",
                     n_txn, done, res_eq, res_gt, res_lt, eq_count);
            if (q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("done_vec", 32'(done), 32'(mon_e.done));
                check("flags", 32'({res_eq, res_gt, res_lt}), 32'(mon_e.flags));
                check("eq_count", 32'(eq_count), 32'(mon_e.cnt));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        rst_n = 1'b0;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) step();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_flags", 32'({res_eq, res_gt, res_lt}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_eq_count", 32'(eq_count), 32'd0);
        rst_n = 1'b1;
        step();

        // Single request, 9 vs 3
        push(2'b01, F_GT);
        a_in[3:0] = 4'd9;
        b_in[3:0] = 4'd3;
        req = 2'b01;
        step();
        check("t1_gnt_e1", 32'(gnt), 32'd1);
        check("t1_busy_e1", 32'(busy), 32'd1);
        step();
        check("t1_done_e2", 32'(done), 32'd1);
        check("t1_gnt_e2", 32'(gnt), 32'd0);
        req = 2'b00;
        step();
        check("t1_done_e3", 32'(done), 32'd0);
        check("t1_busy_e3", 32'(busy), 32'd0);

        // Boundary values on requester 1, flags hold between dones
        run_one(1, 15, 15, F_EQ);
        step();
        step();
        check("t2_hold", 32'({res_eq, res_gt, res_lt}), 32'(F_EQ));
        run_one(1, 0, 15, F_LT);

        // Contention: RR pointer is 0 here, so 0 wins first
        a_in = {4'd2, 4'd5};
        b_in = {4'd7, 4'd5};
        push(2'b01, F_EQ);
        push(2'b10, F_LT);
        push(2'b01, F_EQ);
        req = 2'b11;
        for (int t = 0; t < 3; t++) begin
            cyc = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                cyc++;
                if (gnt != '0) break;
            end
            check("t3_gnt", 32'(gnt), (t == 1) ? 32'd2 : 32'd1);
            if (t > 0) check("t3_spacing", 32'(cyc), 32'd3);
        end
        wait_done(0);
        req = 2'b00;
        step();

        // Reset during CMP aborts the transaction and clears the RR pointer
        a_in[3:0] = 4'd4;
        b_in[3:0] = 4'd4;
        req = 2'b01;
        step();
        check("t4_gnt", 32'(gnt), 32'd1);
        rst_n = 1'b0;
        step();
        check("t4_gnt_rst", 32'(gnt), 32'd0);
        check("t4_done_rst", 32'(done), 32'd0);
        check("t4_flags_rst", 32'({res_eq, res_gt, res_lt}), 32'd0);
        check("t4_busy_rst", 32'(busy), 32'd0);
        exp_cnt = 0;
        rst_n = 1'b1;
        req = 2'b00;
        step();
        a_in = {4'd1, 4'd6};
        b_in = {4'd1, 4'd2};
        push(2'b01, F_GT);
        req = 2'b11;
        step();
        check("t4_rr_ptr", 32'(gnt), 32'd1);
        wait_done(0);
        req = 2'b00;
        step();

        // Operand change after grant is ignored
        run_one(0, 1, 4, F_LT, 8);

        // Equal-result counter: saturation, then unchanged by non-equal compares
        for (int i = 0; i < 300; i++) run_one(0, i % 16, i % 16, F_EQ);
        check("t6_sat", 32'(eq_count), 32'(cnt_exp()));
        run_one(0, 3, 9, F_LT);
        run_one(1, 12, 2, F_GT);
        check("t6_hold", 32'(eq_count), 32'(cnt_exp()));

        repeat (3) step();
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
